// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring divide/remainder behind a valid/ready handshake.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter int MULDIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic             outValid,
  output logic [WIDTH-1:0] outPut,
  output logic [WIDTH-1:0] outHi,
  output logic             isZero,
  output logic             isNeg,
  output logic             carry,
  output logic             overflow,
  output logic             divZero
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH:0]  W_AMT    = (WIDTH + 1)'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SLTS = 4'b1101;
  localparam logic [3:0] OP_EQ0  = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] wrk_hi_q, wrk_hi_d;
  logic [WIDTH-1:0] wrk_lo_q, wrk_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             shift_big_s;
  logic [WIDTH-1:0] alu_res_s;
  logic [WIDTH-1:0] alu_hi_s;
  logic             alu_carry_s;
  logic             alu_ovf_s;
  logic             alu_dz_s;
  logic             alu_multi_s;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_lo_s;
  logic [WIDTH:0]   div_shift_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_rem_s;
  logic [WIDTH-1:0] div_quo_s;

  logic             load_s;
  logic [WIDTH-1:0] new_res_s;
  logic [WIDTH-1:0] new_hi_s;
  logic             new_carry_s;
  logic             new_ovf_s;
  logic             new_dz_s;

  assign sum_s       = {1'b0, aIn} + {1'b0, bIn};
  assign diff_s      = {1'b0, aIn} - {1'b0, bIn};
  assign shift_big_s = ({1'b0, bIn} >= W_AMT);

  // Single-cycle result and flags; flags multi-cycle ops that must iterate
  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_hi_s    = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_dz_s    = 1'b0;
    alu_multi_s = 1'b0;
    case (aluOp)
      OP_ADD: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (aIn[WIDTH-1] == bIn[WIDTH-1]) && (sum_s[WIDTH-1] != aIn[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s   = diff_s[WIDTH-1:0];
        alu_carry_s = diff_s[WIDTH];
        alu_ovf_s   = (aIn[WIDTH-1] != bIn[WIDTH-1]) && (diff_s[WIDTH-1] != aIn[WIDTH-1]);
      end
      OP_OR:   alu_res_s = aIn | bIn;
      OP_XOR:  alu_res_s = aIn ^ bIn;
      OP_AND:  alu_res_s = aIn & bIn;
      OP_NOR:  alu_res_s = ~(aIn | bIn);
      OP_NAND: alu_res_s = ~(aIn & bIn);
      OP_SLL: begin
        if (shift_big_s) alu_res_s = {WIDTH{1'b0}};
        else             alu_res_s = aIn << bIn;
      end
      OP_SRL: begin
        if (shift_big_s) alu_res_s = {WIDTH{1'b0}};
        else             alu_res_s = aIn >> bIn;
      end
      OP_SRA: begin
        if (shift_big_s) alu_res_s = {WIDTH{aIn[WIDTH-1]}};
        else             alu_res_s = $signed(aIn) >>> bIn;
      end
      OP_SLTS: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(aIn) < $signed(bIn))};
      OP_EQ0:  alu_res_s = {{(WIDTH-1){1'b0}}, (aIn == {WIDTH{1'b0}})};
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, (aIn < bIn)};
      OP_MUL: begin
        if (MULDIV != 0) alu_multi_s = 1'b1;
        else             alu_res_s   = {WIDTH{1'b0}};
      end
      // Divide by zero resolves immediately: quotient all ones, remainder = dividend
      OP_DIVU, OP_REMU: begin
        if (MULDIV == 0) begin
          alu_res_s = {WIDTH{1'b0}};
        end else if (bIn == {WIDTH{1'b0}}) begin
          alu_dz_s  = 1'b1;
          alu_res_s = (aluOp == OP_DIVU) ? {WIDTH{1'b1}} : aIn;
          alu_hi_s  = (aluOp == OP_DIVU) ? aIn : {WIDTH{1'b1}};
        end else begin
          alu_multi_s = 1'b1;
        end
      end
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One iteration of shift-add multiply (hi:lo shifts right) or restoring divide (rem:quo shifts left)
  assign mul_sum_s   = {1'b0, wrk_hi_q} + (wrk_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_hi_s    = mul_sum_s[WIDTH:1];
  assign mul_lo_s    = {mul_sum_s[0], wrk_lo_q[WIDTH-1:1]};
  assign div_shift_s = {wrk_hi_q, wrk_lo_q[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, opb_q});
  assign div_rem_s   = div_ge_s ? (div_shift_s[WIDTH-1:0] - opb_q) : div_shift_s[WIDTH-1:0];
  assign div_quo_s   = {wrk_lo_q[WIDTH-2:0], div_ge_s};

  // Next-state: handshake, iteration sequencing and result/flag loading
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opb_d       = opb_q;
    wrk_hi_d    = wrk_hi_q;
    wrk_lo_d    = wrk_lo_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    load_s      = 1'b0;
    new_res_s   = {WIDTH{1'b0}};
    new_hi_s    = {WIDTH{1'b0}};
    new_carry_s = 1'b0;
    new_ovf_s   = 1'b0;
    new_dz_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inValid && alu_multi_s) begin
          state_d  = ST_BUSY;
          op_d     = aluOp;
          opb_d    = bIn;
          wrk_hi_d = {WIDTH{1'b0}};
          wrk_lo_d = aIn;
          cnt_d    = {CW{1'b0}};
        end else if (inValid) begin
          load_s      = 1'b1;
          new_res_s   = alu_res_s;
          new_hi_s    = alu_hi_s;
          new_carry_s = alu_carry_s;
          new_ovf_s   = alu_ovf_s;
          new_dz_s    = alu_dz_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (op_q == OP_MUL) begin
          wrk_hi_d = mul_hi_s;
          wrk_lo_d = mul_lo_s;
        end else begin
          wrk_hi_d = div_rem_s;
          wrk_lo_d = div_quo_s;
        end
        if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          load_s  = 1'b1;
          case (op_q)
            OP_MUL: begin
              new_res_s = mul_lo_s;
              new_hi_s  = mul_hi_s;
            end
            OP_REMU: begin
              new_res_s = div_rem_s;
              new_hi_s  = div_quo_s;
            end
            default: begin
              new_res_s = div_quo_s;
              new_hi_s  = div_rem_s;
            end
          endcase
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_s) begin
      valid_d = 1'b1;
      res_d   = new_res_s;
      hi_d    = new_hi_s;
      zero_d  = (new_res_s == {WIDTH{1'b0}});
      neg_d   = new_res_s[WIDTH-1];
      carry_d = new_carry_s;
      ovf_d   = new_ovf_s;
      dz_d    = new_dz_s;
    end else begin
      res_d   = res_q;
      hi_d    = hi_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
    end
  end

  // State, operand and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 4'b0000;
      opb_q    <= {WIDTH{1'b0}};
      wrk_hi_q <= {WIDTH{1'b0}};
      wrk_lo_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opb_q    <= opb_d;
      wrk_hi_q <= wrk_hi_d;
      wrk_lo_q <= wrk_lo_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      valid_q  <= valid_d;
    end
  end

  assign inReady  = (state_q == ST_IDLE);
  assign outValid = valid_q;
  assign outPut   = res_q;
  assign outHi    = hi_q;
  assign isZero   = zero_q;
  assign isNeg    = neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign divZero  = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16, MULDIV=1).
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [3:0]  aluOp;
  logic [15:0] aIn;
  logic [15:0] bIn;
  logic        outValid;
  logic [15:0] outPut;
  logic [15:0] outHi;
  logic        isZero;
  logic        isNeg;
  logic        carry;
  logic        overflow;
  logic        divZero;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(16), .MULDIV(1)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .aluOp(aluOp), .aIn(aIn), .bIn(bIn), .outValid(outValid),
    .outPut(outPut), .outHi(outHi), .isZero(isZero), .isNeg(isNeg),
    .carry(carry), .overflow(overflow), .divZero(divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // flags order: {isZero, isNeg, carry, overflow, divZero}
  task automatic check_result(input string tag, input logic [15:0] er, input logic [15:0] eh,
                              input logic [4:0] ef);
    check({tag, " valid"}, {31'd0, outValid}, 32'd1);
    check({tag, " outPut"}, {16'd0, outPut}, {16'd0, er});
    check({tag, " outHi"}, {16'd0, outHi}, {16'd0, eh});
    check({tag, " flags"}, {27'd0, isZero, isNeg, carry, overflow, divZero}, {27'd0, ef});
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    inValid = 1'b1;
    aluOp   = op;
    aIn     = a;
    bIn     = b;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic run_multi(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] er, input logic [15:0] eh);
    int n;
    issue(op, a, b);
    inValid = 1'b1;
    aluOp   = 4'b0000;
    aIn     = 16'h0001;
    bIn     = 16'h0001;
    n = 0;
    while (outValid !== 1'b1 && n < 40) begin
      check({tag, " busy inReady"}, {31'd0, inReady}, 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
    inValid = 1'b0;
    check({tag, " latency"}, n, 32'd16);
    check_result(tag, er, eh, {(er == 16'h0000), er[15], 3'b000});
    check({tag, " inReady at result"}, {31'd0, inReady}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, " single pulse"}, {31'd0, outValid}, 32'd0);
    check({tag, " hold"}, {16'd0, outPut}, {16'd0, er});
  endtask

  initial begin
    int vcount;
    reset   = 1'b0;
    inValid = 1'b0;
    aluOp   = 4'b0000;
    aIn     = 16'h0000;
    bIn     = 16'h0000;
    #12;
    check("reset inReady", {31'd0, inReady}, 32'd1);
    check("reset outValid", {31'd0, outValid}, 32'd0);
    check("reset outPut", {16'd0, outPut}, 32'd0);
    check("reset outHi", {16'd0, outHi}, 32'd0);
    check("reset flags", {27'd0, isZero, isNeg, carry, overflow, divZero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(4'b0000, 16'hFFFF, 16'h0001); check_result("add carry", 16'h0000, 16'h0000, 5'b10100);
    issue(4'b0111, 16'h8000, 16'h0001); check_result("sub ovf", 16'h7FFF, 16'h0000, 5'b00010);
    issue(4'b0111, 16'h0001, 16'h0002); check_result("sub borrow", 16'hFFFF, 16'h0000, 5'b01100);
    issue(4'b1101, 16'hFFFF, 16'h0001); check_result("slts", 16'h0001, 16'h0000, 5'b00000);
    issue(4'b1111, 16'hFFFF, 16'h0001); check_result("slt", 16'h0000, 16'h0000, 5'b10000);
    issue(4'b0101, 16'h0001, 16'd16);   check_result("sll 16", 16'h0000, 16'h0000, 5'b10000);
    issue(4'b1100, 16'h8000, 16'd20);   check_result("sra 20", 16'hFFFF, 16'h0000, 5'b01000);
    issue(4'b0110, 16'h8000, 16'd15);   check_result("srl 15", 16'h0001, 16'h0000, 5'b00000);
    issue(4'b0101, 16'h00F1, 16'd4);    check_result("sll 4", 16'h0F10, 16'h0000, 5'b00000);

    @(posedge clk);
    #1;
    check("idle no valid", {31'd0, outValid}, 32'd0);
    check("idle hold", {16'd0, outPut}, 32'h0000_0F10);

    run_multi("mult", 4'b1001, 16'h1234, 16'h5678, 16'h0060, 16'h0626);
    run_multi("divu", 4'b1010, 16'd1000, 16'd7, 16'd142, 16'd6);
    run_multi("remu", 4'b1011, 16'd1000, 16'd7, 16'd6, 16'd142);

    issue(4'b1011, 16'd1000, 16'h0000); check_result("remu by 0", 16'd1000, 16'hFFFF, 5'b00001);
    check("divz inReady", {31'd0, inReady}, 32'd1);
    issue(4'b1010, 16'h8001, 16'h0000); check_result("divu by 0", 16'hFFFF, 16'h8001, 5'b01001);

    // back-to-back single-cycle stream
    issue(4'b0010, 16'hF0F0, 16'h0FF0); check_result("b2b xor", 16'hFF00, 16'h0000, 5'b01000);
    issue(4'b0001, 16'h1200, 16'h0034); check_result("b2b or", 16'h1234, 16'h0000, 5'b00000);
    issue(4'b0011, 16'hFF00, 16'h0F0F); check_result("b2b and", 16'h0F00, 16'h0000, 5'b00000);
    issue(4'b0100, 16'h0000, 16'h0000); check_result("b2b nor", 16'hFFFF, 16'h0000, 5'b01000);
    issue(4'b1000, 16'hFFFF, 16'hFFFF); check_result("b2b nand", 16'h0000, 16'h0000, 5'b10000);
    issue(4'b1110, 16'h0000, 16'h1234); check_result("b2b eq0", 16'h0001, 16'h0000, 5'b00000);

    // reset during divide iterations
    issue(4'b1010, 16'd1000, 16'd7);
    repeat (5) @(posedge clk);
    #1;
    check("mid div busy", {31'd0, inReady}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort inReady", {31'd0, inReady}, 32'd1);
    check("abort outValid", {31'd0, outValid}, 32'd0);
    check("abort outPut", {16'd0, outPut}, 32'd0);
    check("abort outHi", {16'd0, outHi}, 32'd0);
    check("abort flags", {27'd0, isZero, isNeg, carry, overflow, divZero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (outValid === 1'b1) vcount++;
    end
    check("abort no late valid", vcount, 32'd0);
    issue(4'b0000, 16'd2, 16'd3); check_result("add after abort", 16'd5, 16'h0000, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 16-bit combinational ALU, used in the processor execute stage.
- Accepts one operation per valid/ready handshake.
- Single-cycle ops complete in 1 clock; multiply, divide and remainder run as iterative multi-cycle ops.
- Results are returned with registered flags (zero, negative, carry, overflow) and a high-half/remainder output.

Parameters:
WIDTH, 16, datapath width in bits (>=4)
MULDIV, 1, 1 = iterative mult/div/rem present; 0 = those opcodes return 0 in one cycle

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
inValid  input  1  operation request
inReady  output  1  block can accept an operation this cycle
aluOp  input  4  opcode, sampled on accept
aIn  input  WIDTH  operand A, sampled on accept
bIn  input  WIDTH  operand B, sampled on accept
outValid  output  1  one-cycle pulse: result/flags updated
outPut  output  WIDTH  primary result
outHi  output  WIDTH  mult high half / rem quotient / div remainder; 0 for other ops
isZero  output  1  outPut == 0
isNeg  output  1  outPut[WIDTH-1]
carry  output  1  add carry-out; sub borrow (aIn < bIn unsigned); else 0
overflow  output  1  signed overflow for add/sub; else 0
divZero  output  1  div/rem issued with bIn == 0

Behaviour:
- Reset (reset low, asynchronous): state IDLE; inReady 1; outValid 0; outPut, outHi and all flags 0. Reset mid-operation aborts with no outValid.
- Accept: on a rising edge with inValid && inReady. inReady = (state == IDLE), combinational from state only.
- Opcodes:
  - 0000 add; 0001 or; 0010 xor; 0011 and; 0100 nor
  - 0101 sll; 0110 srl; 0111 sub; 1000 nand
  - 1001 mult (unsigned): outPut = low WIDTH bits, outHi = high WIDTH bits
  - 1010 divu: outPut = quotient, outHi = remainder
  - 1011 remu: outPut = remainder, outHi = quotient
  - 1100 sra
  - 1101 slts: signed aIn < bIn -> 1 else 0
  - 1110 eq0: aIn == 0 -> 1 else 0
  - 1111 slt: unsigned aIn < bIn -> 1 else 0
- Shifts: amount = full bIn value. If amount >= WIDTH: sll/srl give 0; sra gives all copies of aIn[WIDTH-1].
- Single-cycle ops, and 1001-1011 when MULDIV=0 (these return outPut = 0):
  - Result and flags registered on the accept edge.
  - outValid high for the following cycle; state stays IDLE.
  - Back-to-back accepts give one result per cycle.
- Multi-cycle ops (MULDIV=1):
  - Accept edge: state goes IDLE->BUSY, operands latched, iteration counter cleared.
  - Mult is shift-add and div/rem is restoring, both 1 bit per cycle, WIDTH iterations on the WIDTH edges after accept.
  - On the final iteration edge: outPut/outHi/flags written, outValid pulses, state returns to IDLE.
  - Total latency is WIDTH+1 edges from accept to outValid-high cycle.
  - inReady is 0 while BUSY; inValid is ignored there, and no request is queued.
- Divide by zero: no iteration. Result registered on the accept edge as a single-cycle op: quotient all ones, remainder = aIn, divZero = 1. divZero = 0 on every other result.
- Flags: update only with a new result, together with outPut; they hold between results.
  - carry and overflow are 0 for non add/sub ops.
  - isZero and isNeg are computed from the final outPut value.
- Hold: outPut, outHi and flags keep their value until the next result edge. outValid is never high two cycles running for one operation.
- Simultaneous events: the outValid cycle of an op is an IDLE cycle, so a new accept can occur in that same cycle.

Test Plan:
- WIDTH=16, add 0xFFFF+0x0001 -> next cycle outValid=1, outPut=0x0000, isZero=1, carry=1, overflow=0.
- sub 0x8000-0x0001 -> outPut=0x7FFF, overflow=1, carry=0. slts 0xFFFF,0x0001 -> 1. slt 0xFFFF,0x0001 -> 0.
- sll 0x0001 by 16 -> 0x0000. sra 0x8000 by 20 -> 0xFFFF. srl 0x8000 by 15 -> 0x0001.
- mult 0x1234*0x5678:
  - inReady low for 16 cycles; outValid in cycle 17 after accept.
  - outPut=0x0060, outHi=0x0626.
  - inValid held during BUSY must not be accepted.
- divu 1000/7 -> outPut=142, outHi=6, 17-cycle latency. remu 1000/0 -> outPut=1000, outHi=0xFFFF, divZero=1, outValid next cycle.
- Assert reset mid-divide at iteration 5 -> outputs 0, inReady 1, no outValid. Then add 2+3 -> outPut=5. Also check back-to-back single-cycle ops stream one result per cycle.
